instr_fetch_unit: RTL and testbench

//  Instruction fetch stage of the single-cycle CPU: owns the PC, fetches 32-bit words

---
 rtl/instr_fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake
// and holds the current instruction for one or more EXEC cycles.
// Optional feature macro: FETCH_TIMEOUT_EN adds a fetch watchdog that raises a
// sticky fetch_err and parks the unit when memory never acknowledges.
module instr_fetch_unit #(
   parameter logic [31:0] PC_RESET    = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_HALT} state_t;

   // Word alignment is forced on the reset vector so imem_addr[1:0] stays 0.
   localparam logic [31:0] PC_INIT = {PC_RESET[31:2], 2'b00};

   // A zero-cycle watchdog would make every fetch fail immediately.
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("instr_fetch_unit: TIMEOUT_CYC must be at least 1");
   end

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        imem_req_q, imem_req_d;
   logic        instr_valid_q, instr_valid_d;
   logic [31:0] pc_plus4_w;
   logic [31:0] br_off;
   logic [31:0] next_pc;
   logic        ack_taken;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fetch_err_q, fetch_err_d;
`endif

   assign ack_taken = imem_ack & imem_req_q;

   // Next-PC selection: jump beats a taken branch, otherwise fall through.
   always_comb begin
      pc_plus4_w = pc_q + 32'd4;
      br_off     = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      if (jump) begin
         next_pc = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
      end else if (branch && zero) begin
         next_pc = pc_plus4_w + br_off;
      end else begin
         next_pc = pc_plus4_w;
      end
   end

   // FSM next-state and registered-output computation.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      imem_req_d    = imem_req_q;
      instr_valid_d = instr_valid_q;
`ifdef FETCH_TIMEOUT_EN
      cnt_d         = cnt_q;
      fetch_err_d   = fetch_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            state_d    = ST_FETCH;
            imem_req_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
            cnt_d      = '0;
`endif
         end
         ST_FETCH: begin
            if (ack_taken) begin
               instr_d       = imem_rdata;
               state_d       = ST_EXEC;
               imem_req_d    = 1'b0;
               instr_valid_d = 1'b1;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               state_d     = ST_HALT;
               imem_req_d  = 1'b0;
               fetch_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         ST_EXEC: begin
            // Branch/jump/zero only matter on the cycle the instruction retires.
            if (!stall) begin
               pc_d          = next_pc;
               state_d       = ST_FETCH;
               imem_req_d    = 1'b1;
               instr_valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
               cnt_d         = '0;
`endif
            end
         end
         ST_HALT: begin
            // Parked after a fetch timeout; only reset leaves this state.
            imem_req_d    = 1'b0;
            instr_valid_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         pc_q          <= PC_INIT;
         instr_q       <= 32'h0;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         cnt_q         <= '0;
         fetch_err_q   <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         imem_req_q    <= imem_req_d;
         instr_valid_q <= instr_valid_d;
`ifdef FETCH_TIMEOUT_EN
         cnt_q         <= cnt_d;
         fetch_err_q   <= fetch_err_d;
`endif
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = {pc_q[31:2], 2'b00};
   assign instr       = instr_q;
   assign op          = instr_q[31:26];
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign pc_plus4    = pc_plus4_w;
`ifdef FETCH_TIMEOUT_EN
   assign fetch_err   = fetch_err_q;
`else
   assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a queue-based scoreboard.
// Build with FETCH_TIMEOUT_EN defined to exercise the fetch watchdog.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n, stall, branch, zero, jump;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4;
   logic [5:0]  op;
   logic        instr_valid, fetch_err;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .zero(zero),
      .jump(jump), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instr(instr), .op(op), .instr_valid(instr_valid),
      .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $error("FAIL sb_empty observed=%h expected=<none>", obs);
         return;
      end
      e = sb.pop_front();
      assert (obs === e.val) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
   endtask

   // One complete fetch/execute transaction starting in FETCH.
   task automatic retire(input logic [31:0] word, input logic br, input logic zr,
                         input logic jp, input logic [31:0] exp_pc,
                         input logic [31:0] exp_next);
      push("fetch_req", 32'd1);
      check({31'd0, imem_req});
      imem_ack   = 1'b1;
      imem_rdata = word;
      push("instr", word);
      push("op", {26'd0, word[31:26]});
      push("valid", 32'd1);
      push("pc", exp_pc);
      push("pc_plus4", exp_pc + 32'd4);
      step();
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      check(instr);
      check({26'd0, op});
      check({31'd0, instr_valid});
      check(pc);
      check(pc_plus4);
      branch = br;
      zero   = zr;
      jump   = jp;
      push("next_addr", exp_next);
      push("valid_drop", 32'd0);
      step();
      branch = 1'b0;
      zero   = 1'b0;
      jump   = 1'b0;
      check(imem_addr);
      check({31'd0, instr_valid});
      $display("txn pc=%h instr=%h -> addr=%h", exp_pc, word, imem_addr);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      logic [31:0] cur;
      rst_n = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
      imem_ack = 1'b0; imem_rdata = 32'h0;

      // Reset state
      step(2);
      push("rst_req", 32'd0);   check({31'd0, imem_req});
      push("rst_valid", 32'd0); check({31'd0, instr_valid});
      push("rst_pc", 32'h0);    check(pc);
      push("rst_instr", 32'h0); check(instr);
      push("rst_err", 32'd0);   check({31'd0, fetch_err});
      $display("txn reset");

      // IDLE -> FETCH one cycle after release
      rst_n = 1'b1;
      step();
      push("first_req", 32'd1); check({31'd0, imem_req});
      push("first_addr", 32'h0); check(imem_addr);

      // Basic fetch, then sequential walk up to 0x10
      retire(32'h2008_0005, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
      retire(32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h4, 32'h8);
      retire(32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h8, 32'hC);
      retire(32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'hC, 32'h10);

      // Branches: taken forward, taken backward, not taken, self-loop
      retire(32'h1000_0003, 1'b1, 1'b1, 1'b0, 32'h10, 32'h20);
      retire(32'h1000_FFFB, 1'b1, 1'b1, 1'b0, 32'h20, 32'h10);
      retire(32'h1000_0003, 1'b1, 1'b0, 1'b0, 32'h10, 32'h14);
      retire(32'h1000_FFFF, 1'b1, 1'b1, 1'b0, 32'h14, 32'h14);

      // Stall for three EXEC cycles with stray acks
      push("stall_req", 32'd1); check({31'd0, imem_req});
      imem_ack = 1'b1; imem_rdata = 32'h0123_4567;
      step();
      stall = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         step();
         push("stall_valid", 32'd1);       check({31'd0, instr_valid});
         push("stall_instr", 32'h0123_4567); check(instr);
         push("stall_pc", 32'h14);          check(pc);
         push("stall_req0", 32'd0);         check({31'd0, imem_req});
         $display("txn stall cycle %0d", i);
      end
      imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
      push("post_stall_addr", 32'h18);
      step();
      check(imem_addr);

      // Jump to 0x400, then climb to 0x1000_0400 with maximal forward branches
      retire(32'h0800_0100, 1'b0, 1'b0, 1'b1, 32'h18, 32'h400);
      cur = 32'h400;
      for (int i = 0; i < 2048; i++) begin
         retire(32'h1000_7FFF, 1'b1, 1'b1, 1'b0, cur, cur + 32'h0002_0000);
         cur = cur + 32'h0002_0000;
      end
      retire(32'h1000_FF0F, 1'b1, 1'b1, 1'b0, 32'h1000_0400, 32'h1000_0040);
      // Jump beats branch and keeps the upper nibble of pc+4
      retire(32'h0800_0100, 1'b1, 1'b1, 1'b1, 32'h1000_0040, 32'h1000_0400);

      // Reset during FETCH, ack arriving after the request was abandoned
      step();
      rst_n = 1'b0;
      step();
      push("midrst_req", 32'd0); check({31'd0, imem_req});
      push("midrst_pc", 32'h0);  check(pc);
      rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000;
      step();
      imem_ack = 1'b0; imem_rdata = 32'h0;
      push("restart_req", 32'd1);  check({31'd0, imem_req});
      push("restart_addr", 32'h0); check(imem_addr);
      push("late_ack_valid", 32'd0); check({31'd0, instr_valid});
      push("late_ack_instr", 32'h0); check(instr);

      // Wrap-around: branch back from 0 to 0xFFFF_FFFC, then fall through to 0
      retire(32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
      retire(32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);

`ifdef FETCH_TIMEOUT_EN
      // Watchdog: 16 FETCH cycles without ack
      step(15);
      push("to_req_before", 32'd1); check({31'd0, imem_req});
      push("to_err_before", 32'd0); check({31'd0, fetch_err});
      step();
      push("to_err", 32'd1); check({31'd0, fetch_err});
      push("to_req", 32'd0); check({31'd0, imem_req});
      imem_ack = 1'b1;
      step(3);
      imem_ack = 1'b0;
      push("halt_err", 32'd1);   check({31'd0, fetch_err});
      push("halt_req", 32'd0);   check({31'd0, imem_req});
      push("halt_valid", 32'd0); check({31'd0, instr_valid});
      rst_n = 1'b0;
      step();
      push("err_clear", 32'd0); check({31'd0, fetch_err});
      rst_n = 1'b1;
      step();
      push("resume_req", 32'd1); check({31'd0, imem_req});
      $display("txn fetch timeout");
`else
      // Without the watchdog FETCH waits indefinitely
      step(20);
      push("wait_req", 32'd1);  check({31'd0, imem_req});
      push("wait_err", 32'd0);  check({31'd0, fetch_err});
      push("wait_addr", 32'h0); check(imem_addr);
      retire(32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
`endif

      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
